// File: rtl/busca_instrucao_if.sv
// Fetch-side bus: instruction memory read port, execute redirect,
// and the registered fetch output handshake toward decode.
interface busca_instrucao_if #(
    parameter int IMEM_AW = 5,
    parameter int BITS    = 32
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [BITS-1:0]    imem_data;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [BITS-1:0]    out_instr;
    logic [31:0]        out_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/busca_instrucao.sv
// Instruction fetch unit: PC, imem address, registered fetch slot,
// redirects and halt on all-zero word. FETCH_COUNT_EN adds fetch_count.
module busca_instrucao #(
    parameter int          IMEM_AW  = 5,
    parameter int          BITS     = 32,
    parameter logic [31:0] RESET_PC = 32'h4
) (
    input  logic                clk,
    input  logic                rst,
    busca_instrucao_if.master   bus,
`ifdef FETCH_COUNT_EN
    output logic [31:0]         fetch_count,
`endif
    output logic                halted
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HALT  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic            out_valid_q, out_valid_d;
    logic [BITS-1:0] out_instr_q, out_instr_d;
    logic [31:0]     out_pc_q, out_pc_d;
    logic            free;

    assign free          = !out_valid_q || bus.out_ready;
    assign bus.imem_addr = pc_q[IMEM_AW+1:2];
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_pc    = out_pc_q;
    assign halted        = (state_q == S_HALT);

    // Next-state: redirect wins, then fetch / halt detection / stall.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        if (bus.redirect_valid) begin
            pc_d        = bus.redirect_pc & ~32'h3;
            out_valid_d = 1'b0;
            state_d     = S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (free) begin
                        if (bus.imem_data != '0) begin
                            out_instr_d = bus.imem_data;
                            out_pc_d    = pc_q;
                            out_valid_d = 1'b1;
                            pc_d        = pc_q + 32'd4;
                        end else begin
                            out_valid_d = 1'b0;
                            state_d     = S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    out_valid_d = 1'b0;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // State and fetch-slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    // Count accepted instructions, wrapping at 2^32.
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (out_valid_q && bus.out_ready) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // Handshake counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: vector table for the main flow,
// hand sequences for wrap and reset-during-stall.
module tb_busca_instrucao;

    logic        clk;
    logic        rst;
    logic        halted;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif
    logic [31:0] mem [32];

    int total;
    int bad;

    busca_instrucao_if #(.IMEM_AW(5), .BITS(32)) bus ();

    assign bus.imem_data = mem[bus.imem_addr];

    busca_instrucao #(
        .IMEM_AW (5),
        .BITS    (32),
        .RESET_PC(32'h4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.master),
`ifdef FETCH_COUNT_EN
        .fetch_count(fetch_count),
`endif
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [4:0]  e_addr;
        logic        e_halt;
    } vec_t;

    vec_t vecs [19];

    function automatic logic [31:0] iw(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rv,
                         input logic [31:0] rpc);
        rst                = r;
        bus.out_ready      = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    task automatic chk_all(input string tag, input logic v,
                           input logic [31:0] pc, input logic [31:0] ins,
                           input logic [4:0] a, input logic h);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, ".pc"}, bus.out_pc, pc);
        chk({tag, ".instr"}, bus.out_instr, ins);
        chk({tag, ".addr"}, 32'(bus.imem_addr), 32'(a));
        chk({tag, ".halt"}, 32'(halted), 32'(h));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) mem[i] = iw(i);
        mem[0] = 32'h0;
        mem[7] = 32'h0;

        //          rst   rdy   rv    rpc     valid pc      instr  addr halt
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0, 5'd1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  iw(1), 5'd2, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h8,  iw(2), 5'd3, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  iw(2), 5'd3, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  iw(2), 5'd3, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  iw(2), 5'd3, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'hC,  iw(3), 5'd4, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h10, iw(4), 5'd5, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h14, iw(5), 5'd6, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h1A, 1'b0, 32'h14, iw(5), 5'd6, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h18, iw(6), 5'd7, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h18, iw(6), 5'd7, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h18, iw(6), 5'd7, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h18, iw(6), 5'd7, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h18, iw(6), 5'd7, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h18, iw(6), 5'd1, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  iw(1), 5'd2, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 32'hB,  1'b0, 32'h4,  iw(1), 5'd2, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h8,  iw(2), 5'd3, 1'b0};

        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
            step();
            chk_all($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                    vecs[i].e_instr, vecs[i].e_addr, vecs[i].e_halt);
`ifdef FETCH_COUNT_EN
            if (i == 0) chk("cnt.reset", fetch_count, 32'd0);
`endif
        end
`ifdef FETCH_COUNT_EN
        chk("cnt.table", fetch_count, 32'd6);
`endif

        // Wrap: pc 0x7C -> addr 31, then pc 0x80 -> addr 0 (word 0 halts).
        drive(1'b0, 1'b1, 1'b1, 32'h7C);
        step();
        chk_all("wrap0", 1'b0, 32'h8, iw(2), 5'd31, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        chk_all("wrap1", 1'b1, 32'h7C, iw(31), 5'd0, 1'b0);
        step();
        chk_all("wrap2", 1'b0, 32'h7C, iw(31), 5'd0, 1'b1);

        // Reset while a fetched word is stalled in the slot.
        drive(1'b0, 1'b1, 1'b1, 32'h10);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk_all("pre_rst", 1'b1, 32'h10, iw(4), 5'd5, 1'b0);
        step();
        chk_all("stall2", 1'b1, 32'h10, iw(4), 5'd5, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'h40);
        step();
        chk_all("rst_mid", 1'b0, 32'h0, 32'h0, 5'd1, 1'b0);
`ifdef FETCH_COUNT_EN
        chk("cnt.rst_mid", fetch_count, 32'd0);
`endif
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        chk_all("post_rst", 1'b1, 32'h4, iw(1), 5'd2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
